hazard_scoreboard: RTL

- Producer-side companion to the EX-stage operand forwarding logic.
- Tracks which architectural registers have results still in flight that forwarding cannot supply:
  - load results one cycle before they reach MEM;
  - results from the long-latency mul/div unit.
- Holds the ID-stage instruction with a stall until its operands are forwardable or written back.
- Sits between decode and issue; completions return from the long-latency unit's writeback port.

---
 rtl/hazard_scoreboard_if.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode/issue and completion bus between the pipeline and hazard_scoreboard.
// The pipeline side drives the ID instruction, flush and long-latency
// completions; the scoreboard returns stall/issue and its tracking state.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned ADDR_W = 5;

  logic                id_valid;
  logic [ADDR_W-1:0]   id_rs1_addr;
  logic [ADDR_W-1:0]   id_rs2_addr;
  logic                id_uses_rs1;
  logic                id_uses_rs2;
  logic [ADDR_W-1:0]   id_rd_addr;
  logic                id_reg_write;
  logic                id_is_load;
  logic                id_long_lat;
  logic                flush;
  logic                lat_done_valid;
  logic [ADDR_W-1:0]   lat_done_rd;
  logic                stall;
  logic                issue_fire;
  logic [NUM_REGS-1:0] pending_mask;
  logic [CNT_W-1:0]    outstanding;
  logic                sb_err;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           id_rd_addr, id_reg_write, id_is_load, id_long_lat, flush,
           lat_done_valid, lat_done_rd,
    input  stall, issue_fire, pending_mask, outstanding, sb_err
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           id_rd_addr, id_reg_write, id_is_load, id_long_lat, flush,
           lat_done_valid, lat_done_rd,
    output stall, issue_fire, pending_mask, outstanding, sb_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: stalls the ID instruction while an operand or its
// destination is still owed by a load in EX or by the long-latency unit.
// Optional protocol checker enabled by defining HAZARD_SB_CHECK_EN; when it
// is undefined sb_err is tied low and no checking logic exists.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned ADDR_W = 5;

  logic                ex_load_valid;
  logic [ADDR_W-1:0]   ex_load_rd;
  logic [NUM_REGS-1:0] pending_mask;
  logic [NUM_REGS-1:0] pending_next;
  logic [CNT_W-1:0]    outstanding;

  logic rs1_q, rs2_q, rd_q;
  logic load_use, raw, waw, full, cap;
  logic stall_c, fire_c;
  logic inc, dec;

  // Operand qualification and hazard detection on registered state
  always_comb begin
    rs1_q    = bus.id_uses_rs1 && (bus.id_rs1_addr != '0);
    rs2_q    = bus.id_uses_rs2 && (bus.id_rs2_addr != '0);
    rd_q     = bus.id_reg_write && (bus.id_rd_addr != '0);
    load_use = ex_load_valid &&
               ((rs1_q && (bus.id_rs1_addr == ex_load_rd)) ||
                (rs2_q && (bus.id_rs2_addr == ex_load_rd)));
    raw      = (rs1_q && pending_mask[bus.id_rs1_addr]) ||
               (rs2_q && pending_mask[bus.id_rs2_addr]);
    waw      = rd_q && pending_mask[bus.id_rd_addr];
    full     = (outstanding == CNT_W'(MAX_OUTSTANDING));
    // Conservative: a completion this cycle does not free a slot for issue
    cap      = bus.id_long_lat && full;
    stall_c  = !rst && bus.id_valid && (load_use || raw || waw || cap);
    fire_c   = bus.id_valid && !stall_c && !bus.flush && !rst;
    inc      = fire_c && bus.id_long_lat;
    dec      = bus.lat_done_valid;
  end

  // Load in EX: its result becomes forwardable one cycle later from MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_load_valid <= 1'b0;
      ex_load_rd    <= '0;
    end else begin
      ex_load_valid <= fire_c && bus.id_is_load && rd_q;
      ex_load_rd    <= bus.id_rd_addr;
    end
  end

  // Pending bits: clear on completion first so a same-cycle new issue wins
  always_comb begin
    pending_next = pending_mask;
    if (bus.lat_done_valid && (bus.lat_done_rd != '0)) begin
      pending_next[bus.lat_done_rd] = 1'b0;
    end
    if (fire_c && bus.id_long_lat && rd_q) begin
      pending_next[bus.id_rd_addr] = 1'b1;
    end
  end

  // Pending-mask register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_mask <= '0;
    end else begin
      pending_mask <= pending_next;
    end
  end

  // In-flight long-latency counter, saturating at both ends
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (inc && !dec && !full) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (dec && !inc && (outstanding != '0)) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

`ifdef HAZARD_SB_CHECK_EN
  logic sb_err;
  logic err_c;

  // Protocol violations: unmatched completion, underflow, issue past capacity
  // (the last is masked by the capacity stall and guards against its removal)
  always_comb begin
    err_c = (bus.lat_done_valid && (bus.lat_done_rd != '0) &&
             !pending_mask[bus.lat_done_rd]) ||
            (bus.lat_done_valid && (outstanding == '0)) ||
            (fire_c && bus.id_long_lat && full);
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (err_c) begin
      sb_err <= 1'b1;
    end
  end

`ifdef SIMULATION
  // Report each violation with the completing register and in-flight count
  always_ff @(posedge clk) begin
    if (!rst && err_c) begin
      $display("hazard_scoreboard: protocol error rd=%0d outstanding=%0d",
               bus.lat_done_rd, outstanding);
    end
  end
`endif

  assign bus.sb_err = sb_err;
`else
  assign bus.sb_err = 1'b0;
`endif

  assign bus.stall        = stall_c;
  assign bus.issue_fire   = fire_c;
  assign bus.pending_mask = pending_mask;
  assign bus.outstanding  = outstanding;

endmodule
